// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: assembles a 4-digit code, compares it with the stored password,
// drives unlock / set-mode enable and enforces a lockout after repeated failures.
module lock_ctrl #(
    parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
    parameter int unsigned ENTRY_TIMEOUT  = 500_000_000,
    parameter int unsigned SET_TIMEOUT    = 1_000_000_000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        push_pulse,
    input  logic        hold_pulse,
    input  logic [3:0]  value_4bit,
    input  logic [15:0] pw_stored,
    input  logic        pw_commit,
    output logic        enb_set,
    output logic        unlock,
    output logic        alarm,
    output logic [2:0]  digit_idx,
    output logic [2:0]  fail_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_SET     = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    // Timer is loaded with N-1 so the state lasts exactly N cycles.
    localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0] ENTRY_LOAD   = 32'(ENTRY_TIMEOUT - 1);
    localparam logic [31:0] SET_LOAD     = 32'(SET_TIMEOUT - 1);
    localparam logic [2:0]  FAIL_MAX     = 3'(MAX_FAIL);
    localparam logic [2:0]  FAIL_LAST    = 3'(MAX_FAIL - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] code_q, code_d;
    logic [2:0]  digit_idx_q, digit_idx_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic [31:0] tmr_q, tmr_d;
    logic        tmr_zero;

    assign tmr_zero = (tmr_q == 32'd0);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        digit_idx_d = digit_idx_q;
        fail_cnt_d  = fail_cnt_q;
        tmr_d       = tmr_q;

        case (state_q)
            ST_IDLE: begin
                // Hold wins over a simultaneous push, so both are dropped here.
                if (push_pulse && !hold_pulse) begin
                    code_d      = {12'h000, value_4bit};
                    digit_idx_d = 3'd1;
                    tmr_d       = ENTRY_LOAD;
                    state_d     = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (hold_pulse) begin
                    code_d      = 16'h0000;
                    digit_idx_d = 3'd0;
                    state_d     = ST_IDLE;
                end else if (push_pulse) begin
                    code_d[{digit_idx_q[1:0], 2'b00} +: 4] = value_4bit;
                    digit_idx_d = digit_idx_q + 3'd1;
                    tmr_d       = ENTRY_LOAD;
                    if (digit_idx_q == 3'd3) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmr_zero) begin
                    code_d      = 16'h0000;
                    digit_idx_d = 3'd0;
                    state_d     = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end

            ST_CHECK: begin
                code_d      = 16'h0000;
                digit_idx_d = 3'd0;
                if (code_q == pw_stored) begin
                    fail_cnt_d = 3'd0;
                    tmr_d      = UNLOCK_LOAD;
                    state_d    = ST_OPEN;
                end else if (fail_cnt_q >= FAIL_LAST) begin
                    fail_cnt_d = FAIL_MAX;
                    tmr_d      = LOCKOUT_LOAD;
                    state_d    = ST_LOCKOUT;
                end else begin
                    fail_cnt_d = fail_cnt_q + 3'd1;
                    state_d    = ST_IDLE;
                end
            end

            ST_OPEN: begin
                if (hold_pulse) begin
                    tmr_d   = SET_LOAD;
                    state_d = ST_SET;
                end else if (push_pulse || tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end

            ST_SET: begin
                if (pw_commit || tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end

            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    fail_cnt_d = 3'd0;
                    state_d    = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end

            default: begin
                code_d      = 16'h0000;
                digit_idx_d = 3'd0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= 16'h0000;
            digit_idx_q <= 3'd0;
            fail_cnt_q  <= 3'd0;
            tmr_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            digit_idx_q <= digit_idx_d;
            fail_cnt_q  <= fail_cnt_d;
            tmr_q       <= tmr_d;
        end
    end

    assign unlock    = (state_q == ST_OPEN);
    assign alarm     = (state_q == ST_LOCKOUT);
    assign enb_set   = (state_q == ST_SET);
    assign digit_idx = digit_idx_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: each entry pushes its expected outcome to a scoreboard
// that is popped when the FSM leaves CHECK.
module tb_lock_ctrl;

    localparam int unsigned UNL  = 8;
    localparam int unsigned LCK  = 16;
    localparam int unsigned ENT  = 20;
    localparam int unsigned SETT = 32;
    localparam int unsigned MF   = 3;
    localparam logic [15:0] PW   = 16'h4321;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        push_pulse;
    logic        hold_pulse;
    logic [3:0]  value_4bit;
    logic [15:0] pw_stored;
    logic        pw_commit;
    logic        enb_set;
    logic        unlock;
    logic        alarm;
    logic [2:0]  digit_idx;
    logic [2:0]  fail_cnt;

    typedef struct packed {
        logic       unl;
        logic       alm;
        logic [2:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mf    = 0;

    lock_ctrl #(
        .UNLOCK_CYCLES (UNL),
        .LOCKOUT_CYCLES(LCK),
        .ENTRY_TIMEOUT (ENT),
        .SET_TIMEOUT   (SETT),
        .MAX_FAIL      (MF)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .push_pulse(push_pulse),
        .hold_pulse(hold_pulse),
        .value_4bit(value_4bit),
        .pw_stored (pw_stored),
        .pw_commit (pw_commit),
        .enb_set   (enb_set),
        .unlock    (unlock),
        .alarm     (alarm),
        .digit_idx (digit_idx),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_digit(input logic [3:0] d);
        value_4bit = d;
        push_pulse = 1'b1;
        tick();
        push_pulse = 1'b0;
    endtask

    // Enter four digits (digit 1 from [3:0]) and queue the expected verdict.
    task automatic enter_code(input logic [15:0] code);
        exp_t e;
        for (int k = 0; k < 4; k++) push_digit(code[4*k +: 4]);
        if (code == PW) begin
            mf = 0;
            e  = '{unl: 1'b1, alm: 1'b0, fc: 3'd0};
        end else begin
            mf = (mf + 1 >= int'(MF)) ? int'(MF) : mf + 1;
            e  = '{unl: 1'b0, alm: (mf == int'(MF)), fc: 3'(mf)};
        end
        sb_q.push_back(e);
    endtask

    task automatic check_outcome(input string name);
        exp_t e;
        tick();
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: outcome with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            if ({unlock, alarm, fail_cnt} !== {e.unl, e.alm, e.fc}) begin
                n_err++;
                $display("FAIL %s: unlock/alarm/fail_cnt got %b/%b/%0d expected %b/%b/%0d",
                         name, unlock, alarm, fail_cnt, e.unl, e.alm, e.fc);
            end
        end
        n_cmp++;
        if (digit_idx !== 3'd0) begin
            n_err++;
            $display("FAIL %s_idx_clr: digit_idx got %0d expected 0", name, digit_idx);
        end
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((unlock !== 1'b0 || alarm !== 1'b0 || enb_set !== 1'b0) && n < 200) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL wait_quiet: outputs still active after %0d cycles, expected idle", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({enb_set, unlock, alarm, digit_idx, fail_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_hold: outputs got %b expected 0",
                     {enb_set, unlock, alarm, digit_idx, fail_cnt});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({enb_set, unlock, alarm, digit_idx, fail_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_release: outputs got %b expected 0",
                     {enb_set, unlock, alarm, digit_idx, fail_cnt});
        end
    endtask

    task automatic test_correct_code();
        int cnt = 0;
        enter_code(PW);
        n_cmp++;
        if (unlock !== 1'b0) begin
            n_err++;
            $display("FAIL unlock_early: unlock got %b in CHECK expected 0", unlock);
        end
        check_outcome("correct_code");
        while (unlock === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != int'(UNL)) begin
            n_err++;
            $display("FAIL unlock_len: got %0d cycles expected %0d", cnt, UNL);
        end
    endtask

    task automatic test_lockout();
        int cnt = 0;
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h1111);
            check_outcome("lockout_try");
        end
        while (alarm === 1'b1 && cnt < 100) begin
            value_4bit = 4'h4;
            push_pulse = (cnt % 3 == 0);
            hold_pulse = (cnt == 7);
            cnt++;
            tick();
        end
        push_pulse = 1'b0;
        hold_pulse = 1'b0;
        mf = 0;
        n_cmp++;
        if (cnt != int'(LCK)) begin
            n_err++;
            $display("FAIL alarm_len: got %0d cycles expected %0d", cnt, LCK);
        end
        n_cmp++;
        if ({fail_cnt, digit_idx, unlock} !== 7'b0) begin
            n_err++;
            $display("FAIL lockout_exit: fail_cnt/digit_idx/unlock got %0d/%0d/%b expected 0/0/0",
                     fail_cnt, digit_idx, unlock);
        end
    endtask

    task automatic test_entry_timeout();
        push_digit(4'h1);
        n_cmp++;
        if (digit_idx !== 3'd1) begin
            n_err++;
            $display("FAIL idx_first: digit_idx got %0d expected 1", digit_idx);
        end
        push_digit(4'h2);
        n_cmp++;
        if (digit_idx !== 3'd2) begin
            n_err++;
            $display("FAIL idx_second: digit_idx got %0d expected 2", digit_idx);
        end
        repeat (ENT - 1) tick();
        n_cmp++;
        if (digit_idx !== 3'd2) begin
            n_err++;
            $display("FAIL timeout_early: digit_idx got %0d expected 2", digit_idx);
        end
        tick();
        n_cmp++;
        if (digit_idx !== 3'd0) begin
            n_err++;
            $display("FAIL timeout_fire: digit_idx got %0d expected 0", digit_idx);
        end
        enter_code(PW);
        check_outcome("after_timeout");
        wait_quiet();
    endtask

    task automatic test_set_mode();
        int cnt = 0;
        enter_code(PW);
        check_outcome("set_unlock1");
        hold_pulse = 1'b1;
        tick();
        hold_pulse = 1'b0;
        n_cmp++;
        if ({enb_set, unlock} !== 2'b10) begin
            n_err++;
            $display("FAIL set_enter: enb_set/unlock got %b/%b expected 1/0", enb_set, unlock);
        end
        push_digit(4'h9);
        tick();
        n_cmp++;
        if (enb_set !== 1'b1) begin
            n_err++;
            $display("FAIL set_push_ignored: enb_set got %b expected 1", enb_set);
        end
        pw_commit = 1'b1;
        tick();
        pw_commit = 1'b0;
        n_cmp++;
        if (enb_set !== 1'b0) begin
            n_err++;
            $display("FAIL set_commit: enb_set got %b expected 0", enb_set);
        end
        enter_code(PW);
        check_outcome("set_unlock2");
        hold_pulse = 1'b1;
        tick();
        hold_pulse = 1'b0;
        while (enb_set === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != int'(SETT)) begin
            n_err++;
            $display("FAIL set_timeout: enb_set high %0d cycles expected %0d", cnt, SETT);
        end
    endtask

    task automatic test_simul_and_relock();
        push_digit(4'h1);
        push_digit(4'h2);
        push_digit(4'h3);
        n_cmp++;
        if (digit_idx !== 3'd3) begin
            n_err++;
            $display("FAIL idx_three: digit_idx got %0d expected 3", digit_idx);
        end
        value_4bit = 4'h4;
        push_pulse = 1'b1;
        hold_pulse = 1'b1;
        tick();
        push_pulse = 1'b0;
        hold_pulse = 1'b0;
        n_cmp++;
        if (digit_idx !== 3'd0) begin
            n_err++;
            $display("FAIL simul_abort: digit_idx got %0d expected 0", digit_idx);
        end
        tick();
        n_cmp++;
        if ({unlock, alarm, fail_cnt} !== {2'b00, 3'(mf)}) begin
            n_err++;
            $display("FAIL simul_no_check: unlock/alarm/fail_cnt got %b/%b/%0d expected 0/0/%0d",
                     unlock, alarm, fail_cnt, mf);
        end
        enter_code(PW);
        check_outcome("relock_open");
        push_pulse = 1'b1;
        tick();
        push_pulse = 1'b0;
        n_cmp++;
        if (unlock !== 1'b0) begin
            n_err++;
            $display("FAIL relock: unlock got %b expected 0", unlock);
        end
    endtask

    task automatic reset_pulse(input string name);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({enb_set, unlock, alarm, digit_idx, fail_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL %s_async: outputs got %b expected 0", name,
                     {enb_set, unlock, alarm, digit_idx, fail_cnt});
        end
        mf = 0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({enb_set, unlock, alarm, digit_idx, fail_cnt} !== 9'b0) begin
            n_err++;
            $display("FAIL %s_release: outputs got %b expected 0", name,
                     {enb_set, unlock, alarm, digit_idx, fail_cnt});
        end
    endtask

    task automatic test_mid_reset();
        enter_code(PW);
        check_outcome("reset_open");
        tick();
        reset_pulse("rst_open");
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h1111);
            check_outcome("reset_lock_try");
        end
        repeat (3) tick();
        reset_pulse("rst_lockout");
        enter_code(PW);
        check_outcome("post_reset_unlock");
        wait_quiet();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        push_pulse = 1'b0;
        hold_pulse = 1'b0;
        value_4bit = 4'h0;
        pw_commit  = 1'b0;
        pw_stored  = PW;
        test_reset();
        test_correct_code();
        test_lockout();
        test_entry_timeout();
        test_set_mode();
        test_simul_and_relock();
        wait_quiet();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
